mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register and write-back selector directly upstream of Regfile.
//  - Captures results leaving the MEM stage: ALU result, load data, link address, control.
//  - Produces Regfile's write-side inputs: RegWr, Rw, Busw.
//  - Suppresses writes on arithmetic overflow and on writes to $0.
//  - Provides forwarding taps, an overflow exception pulse and a retired-instruction counter.
// PARAMETERS
//  DATA_W    32   datapath width
//  REG_AW    5    register index width
//  LINK_REG  31   destination register for link (JAL/JALR) writes
//  CNT_W     32   retire counter width
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous reset, active low
//  stall        in   1        hold stage contents
//  flush        in   1        replace captured instruction with bubble
//  m_valid      in   1        MEM stage holds a real instruction
//  m_RegWr      in   1        instruction writes a register
//  m_Overflow   in   1        ALU signed overflow for this instruction
//  m_RegDst     in   1        0: Rw=Rt, 1: Rw=Rd
//  m_MemtoReg   in   1        0: ALU result, 1: load data
//  m_Link       in   1        Rw=LINK_REG, Busw=pc+8 (overrides RegDst/MemtoReg)
//  m_ldtype     in   3        load type (package constants)
//  m_Rt, m_Rd   in   REG_AW   candidate destinations
//  m_alu        in   DATA_W   ALU result / effective address
//  m_rdata      in   DATA_W   raw aligned word from data memory
//  m_pc         in   DATA_W   instruction PC
//  RegWr        out  1        to Regfile write enable
//  Rw           out  REG_AW   to Regfile write index
//  Busw         out  DATA_W   to Regfile write data
//  exc_ovf      out  1        one-cycle overflow exception pulse
//  retire_cnt   out  CNT_W    count of valid instructions captured
// BEHAVIOUR
//  Reset: rst_n=0 at a rising edge clears all state: RegWr=0, Rw=0, Busw=0, exc_ovf=0, retire_cnt=0. Any in-flight instruction is discarded.
//  Capture: one-cycle latency. Inputs are sampled at posedge; outputs are registered, with no combinational path from input to output. Regfile commits on the following edge.
//  Priority per edge: rst_n=0 > flush > stall > capture.
//   - flush: stage loads a bubble (RegWr=0, Rw=0, Busw=0, exc_ovf=0).
//   - stall: stage holds all registers. A held RegWr=1 rewrites the same value, which is idempotent and legal. exc_ovf is cleared after its first cycle, so it never repeats. retire_cnt does not change.
//  Rw: m_Link ? LINK_REG : (m_RegDst ? m_Rd : m_Rt).
//  Busw: m_Link ? m_pc+8 : (m_MemtoReg ? load_align(m_rdata) : m_alu). m_pc+8 wraps modulo 2^DATA_W.
//  RegWr = m_valid & m_RegWr & ~m_Overflow & (Rw != 0).
//  exc_ovf = m_valid & m_Overflow, registered. m_Overflow with m_valid=0 is ignored.
//  retire_cnt: +1 per captured instruction with m_valid=1, overflowing ones included. Wraps from 2^CNT_W-1 to 0. Bubbles and held cycles do not count.
//  Load align (little-endian, lane select from m_alu[1:0]):
//   - LW: full word.
//   - LB/LBU: byte lane m_alu[1:0], sign- or zero-extended.
//   - LH/LHU: half selected by m_alu[1]; m_alu[0] is ignored.
//   - Unused ldtype codes behave as LW.
//  Forwarding: RegWr, Rw and Busw double as the WB forwarding source.
// STRUCTURE
//  Package cpu_pkg:
//   - LD_W=3'd0, LD_B=3'd1, LD_BU=3'd2, LD_H=3'd3, LD_HU=3'd4.
//   - LINK_REG default value.
//  Sub-module load_align: combinational (rdata, addr[1:0], ldtype) -> DATA_W result.
//  Top level: one pipeline register block plus the retire counter.
// TESTING
//  1 R-type write: m_valid=1, m_RegWr=1, m_RegDst=1, Rt=5, Rd=9, alu=0x1234 -> next cycle RegWr=1, Rw=9, Busw=0x00001234, retire_cnt=1.
//  2 Overflow: same stimulus with m_Overflow=1 -> RegWr=0, exc_ovf=1 for exactly one cycle, retire_cnt=1.
//  3 Loads with m_rdata=0x80FF7F01:
//   - LB, alu[1:0]=3 -> Busw=0xFFFFFF80.
//   - LBU, alu[1:0]=3 -> Busw=0x00000080.
//   - LH, alu[1]=0 -> Busw=0x00007F01.
//   - LHU, alu[1]=1 -> Busw=0x000080FF.
//  4 Link: m_Link=1, m_pc=0x00400010 -> Rw=31, Busw=0x00400018, RegWr=1.
//  5 Control:
//   - stall=1 and flush=1 together -> bubble (RegWr=0).
//   - stall for 3 cycles -> outputs and retire_cnt held, exc_ovf not repeated.
//   - RegWr=1 with Rw=0 -> RegWr=0.
//  6 Reset mid-operation: rst_n=0 while a valid write is captured -> next edge all outputs 0. After release, the first instruction retires with retire_cnt=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the MEM/WB stage: load-type codes and the link register.
package cpu_pkg;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  localparam int LINK_REG_DEFAULT = 31;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bundle: MEM-stage results and control going in, Regfile write side,
// exception pulse and retire count coming out.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic              stall;
  logic              flush;
  logic              m_valid;
  logic              m_RegWr;
  logic              m_Overflow;
  logic              m_RegDst;
  logic              m_MemtoReg;
  logic              m_Link;
  logic [2:0]        m_ldtype;
  logic [REG_AW-1:0] m_Rt;
  logic [REG_AW-1:0] m_Rd;
  logic [DATA_W-1:0] m_alu;
  logic [DATA_W-1:0] m_rdata;
  logic [DATA_W-1:0] m_pc;

  logic              RegWr;
  logic [REG_AW-1:0] Rw;
  logic [DATA_W-1:0] Busw;
  logic              exc_ovf;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output stall, flush, m_valid, m_RegWr, m_Overflow, m_RegDst, m_MemtoReg,
           m_Link, m_ldtype, m_Rt, m_Rd, m_alu, m_rdata, m_pc,
    input  RegWr, Rw, Busw, exc_ovf, retire_cnt
  );

  modport slave (
    input  stall, flush, m_valid, m_RegWr, m_Overflow, m_RegDst, m_MemtoReg,
           m_Link, m_ldtype, m_Rt, m_Rd, m_alu, m_rdata, m_pc,
    output RegWr, Rw, Busw, exc_ovf, retire_cnt
  );

endinterface

// File: rtl/load_align.sv
// Little-endian load alignment: picks the byte/half lane addressed by the low
// address bits and sign- or zero-extends it; unknown load types pass the word.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        ldtype,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select followed by extension according to load type
  always_comb begin
    byte_v = rdata[7:0];
    case (addr)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    // addr[0] is deliberately ignored for halfword loads
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (ldtype)
      LD_B:    result = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LD_BU:   result = {{(DATA_W-8){1'b0}}, byte_v};
      LD_H:    result = {{(DATA_W-16){half_v[15]}}, half_v};
      LD_HU:   result = {{(DATA_W-16){1'b0}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register feeding the Regfile write port. Selects the
// destination and write-back data, suppresses writes on overflow or to $0,
// raises a one-cycle overflow pulse and counts retired instructions.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = LINK_REG_DEFAULT,
  parameter int CNT_W    = 32
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);

  logic [DATA_W-1:0] ld_data_p0;
  logic [DATA_W-1:0] busw_p0;
  logic [REG_AW-1:0] rw_p0;
  logic              regwr_p0;
  logic              ovf_p0;
  logic              vld_p0;

  logic [DATA_W-1:0] busw_p1;
  logic [REG_AW-1:0] rw_p1;
  logic              regwr_p1;
  logic              ovf_p1;
  logic [CNT_W-1:0]  cnt_p1;

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata  (bus.m_rdata),
    .addr   (bus.m_alu[1:0]),
    .ldtype (bus.m_ldtype),
    .result (ld_data_p0)
  );

  // ---- p0: MEM-side decode of destination, data and qualified write enable
  always_comb begin
    vld_p0 = bus.m_valid;
    if (bus.m_Link)        rw_p0 = REG_AW'(LINK_REG);
    else if (bus.m_RegDst) rw_p0 = bus.m_Rd;
    else                   rw_p0 = bus.m_Rt;

    if (bus.m_Link)          busw_p0 = bus.m_pc + DATA_W'(8);
    else if (bus.m_MemtoReg) busw_p0 = ld_data_p0;
    else                     busw_p0 = bus.m_alu;

    regwr_p0 = vld_p0 & bus.m_RegWr & ~bus.m_Overflow & (rw_p0 != '0);
    ovf_p0   = vld_p0 & bus.m_Overflow;
  end

  // ---- p1: pipeline register; flush inserts a bubble, stall holds but drops the pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwr_p1 <= 1'b0;
      rw_p1    <= '0;
      busw_p1  <= '0;
      ovf_p1   <= 1'b0;
    end else if (bus.flush) begin
      regwr_p1 <= 1'b0;
      rw_p1    <= '0;
      busw_p1  <= '0;
      ovf_p1   <= 1'b0;
    end else if (bus.stall) begin
      ovf_p1   <= 1'b0;
    end else begin
      regwr_p1 <= regwr_p0;
      rw_p1    <= rw_p0;
      busw_p1  <= busw_p0;
      ovf_p1   <= ovf_p0;
    end
  end

  // Retire counter: one count per valid instruction actually captured
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (!bus.flush && !bus.stall && vld_p0) begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  assign bus.RegWr      = regwr_p1;
  assign bus.Rw         = rw_p1;
  assign bus.Busw       = busw_p1;
  assign bus.exc_ovf    = ovf_p1;
  assign bus.retire_cnt = cnt_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand-written control
// sequences, then randomized traffic against a behavioural model.
module tb_mem_wb_stage;
  import cpu_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  mem_wb_stage #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .LINK_REG (31),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic        valid, regwr, ovf, regdst, memtoreg, link;
    logic [2:0]  ld;
    logic [4:0]  rt, rd;
    logic [31:0] alu, rdata, pc;
    logic        e_regwr;
    logic [4:0]  e_rw;
    logic [31:0] e_busw;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_cnt;

  // model state for the random phase
  logic        m_regwr, m_ovf;
  logic [4:0]  m_rw;
  logic [31:0] m_busw, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic valid, input logic regwr,
                              input logic ovf, input logic regdst, input logic memtoreg,
                              input logic link, input logic [2:0] ld, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] rdata, input logic [31:0] pc,
                              input logic e_regwr, input logic [4:0] e_rw,
                              input logic [31:0] e_busw, input logic e_ovf);
    vec_t v;
    v.name = nm; v.valid = valid; v.regwr = regwr; v.ovf = ovf; v.regdst = regdst;
    v.memtoreg = memtoreg; v.link = link; v.ld = ld; v.rt = rt; v.rd = rd;
    v.alu = alu; v.rdata = rdata; v.pc = pc;
    v.e_regwr = e_regwr; v.e_rw = e_rw; v.e_busw = e_busw; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus.m_valid = v.valid; bus.m_RegWr = v.regwr; bus.m_Overflow = v.ovf;
    bus.m_RegDst = v.regdst; bus.m_MemtoReg = v.memtoreg; bus.m_Link = v.link;
    bus.m_ldtype = v.ld; bus.m_Rt = v.rt; bus.m_Rd = v.rd;
    bus.m_alu = v.alu; bus.m_rdata = v.rdata; bus.m_pc = v.pc;
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.m_valid = 1'b0; bus.m_RegWr = 1'b0; bus.m_Overflow = 1'b0;
    bus.m_RegDst = 1'b0; bus.m_MemtoReg = 1'b0; bus.m_Link = 1'b0;
    bus.m_ldtype = LD_W; bus.m_Rt = '0; bus.m_Rd = '0;
    bus.m_alu = '0; bus.m_rdata = '0; bus.m_pc = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic regwr, input logic [4:0] rw,
                         input logic [31:0] busw, input logic ovf, input logic [31:0] cnt);
    chk({tag, ".RegWr"},      32'(bus.RegWr),   32'(regwr));
    chk({tag, ".Rw"},         32'(bus.Rw),      32'(rw));
    chk({tag, ".Busw"},       bus.Busw,         busw);
    chk({tag, ".exc_ovf"},    32'(bus.exc_ovf), 32'(ovf));
    chk({tag, ".retire_cnt"}, bus.retire_cnt,   cnt);
  endtask

  // Write-back value from the architectural rules, with plain shifts and masks
  function automatic logic [31:0] ref_busw(input logic link, input logic mtr, input logic [2:0] ld,
                                           input logic [31:0] alu, input logic [31:0] rdata,
                                           input logic [31:0] pc);
    int unsigned lane, hsel;
    logic [31:0] b, h;
    if (link) return pc + 32'd8;
    if (!mtr) return alu;
    lane = int'(alu[1:0]);
    hsel = int'(alu[1]);
    b = (rdata >> (8 * lane)) & 32'hFF;
    h = (rdata >> (16 * hsel)) & 32'hFFFF;
    case (ld)
      LD_B:    return (b >= 32'd128)   ? b - 32'd256   : b;
      LD_BU:   return b;
      LD_H:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      LD_HU:   return h;
      default: return rdata;
    endcase
  endfunction

  task automatic model_edge();
    logic [4:0] dst;
    if (!rst_n) begin
      m_regwr = 0; m_rw = 0; m_busw = 0; m_ovf = 0; m_cnt = 0;
    end else if (bus.flush) begin
      m_regwr = 0; m_rw = 0; m_busw = 0; m_ovf = 0;
    end else if (bus.stall) begin
      m_ovf = 0;
    end else begin
      dst = bus.m_Link ? 5'd31 : (bus.m_RegDst ? bus.m_Rd : bus.m_Rt);
      m_rw    = dst;
      m_busw  = ref_busw(bus.m_Link, bus.m_MemtoReg, bus.m_ldtype, bus.m_alu, bus.m_rdata, bus.m_pc);
      m_regwr = bus.m_valid && bus.m_RegWr && !bus.m_Overflow && (dst != 5'd0);
      m_ovf   = bus.m_valid && bus.m_Overflow;
      if (bus.m_valid) m_cnt = m_cnt + 32'd1;
    end
  endtask

  localparam logic [31:0] RD = 32'h80FF7F01;

  initial begin
    vec_t v;
    //              name        vl rw ov dst mtr lk ld     rt     rd     alu           rdata  pc             eRW eRw    eBusw          eOvf
    vecs.push_back(mk("rtype",   1, 1, 0, 1, 0, 0, LD_W,  5'd5,  5'd9,  32'h1234,     0,     0,             1, 5'd9,  32'h00001234,  0));
    vecs.push_back(mk("ovf",     1, 1, 1, 1, 0, 0, LD_W,  5'd5,  5'd9,  32'h1234,     0,     0,             0, 5'd9,  32'h00001234,  1));
    vecs.push_back(mk("lb3",     1, 1, 0, 0, 1, 0, LD_B,  5'd7,  5'd9,  32'h1003,     RD,    0,             1, 5'd7,  32'hFFFFFF80,  0));
    vecs.push_back(mk("lbu3",    1, 1, 0, 0, 1, 0, LD_BU, 5'd7,  5'd9,  32'h1003,     RD,    0,             1, 5'd7,  32'h00000080,  0));
    vecs.push_back(mk("lh0",     1, 1, 0, 0, 1, 0, LD_H,  5'd7,  5'd9,  32'h1000,     RD,    0,             1, 5'd7,  32'h00007F01,  0));
    vecs.push_back(mk("lhu2",    1, 1, 0, 0, 1, 0, LD_HU, 5'd7,  5'd9,  32'h1002,     RD,    0,             1, 5'd7,  32'h000080FF,  0));
    vecs.push_back(mk("lh3",     1, 1, 0, 0, 1, 0, LD_H,  5'd7,  5'd9,  32'h1003,     RD,    0,             1, 5'd7,  32'hFFFF80FF,  0));
    vecs.push_back(mk("lb1",     1, 1, 0, 0, 1, 0, LD_B,  5'd7,  5'd9,  32'h1001,     RD,    0,             1, 5'd7,  32'h0000007F,  0));
    vecs.push_back(mk("lw",      1, 1, 0, 0, 1, 0, LD_W,  5'd7,  5'd9,  32'h1002,     RD,    0,             1, 5'd7,  RD,            0));
    vecs.push_back(mk("ld7",     1, 1, 0, 0, 1, 0, 3'd7,  5'd7,  5'd9,  32'h1003,     RD,    0,             1, 5'd7,  RD,            0));
    vecs.push_back(mk("link",    1, 1, 0, 1, 1, 1, LD_B,  5'd5,  5'd9,  32'h1003,     RD,    32'h00400010,  1, 5'd31, 32'h00400018,  0));
    vecs.push_back(mk("linkwrap",1, 1, 0, 0, 0, 1, LD_W,  5'd5,  5'd9,  32'h1,        0,     32'hFFFFFFFC,  1, 5'd31, 32'h00000004,  0));
    vecs.push_back(mk("rw0",     1, 1, 0, 0, 0, 0, LD_W,  5'd0,  5'd9,  32'hABCD,     0,     0,             0, 5'd0,  32'h0000ABCD,  0));
    vecs.push_back(mk("inv_ovf", 0, 1, 1, 1, 0, 0, LD_W,  5'd5,  5'd3,  32'h77,       0,     0,             0, 5'd3,  32'h00000077,  0));
    vecs.push_back(mk("nowr",    1, 0, 0, 1, 0, 0, LD_W,  5'd5,  5'd4,  32'h99,       0,     0,             0, 5'd4,  32'h00000099,  0));

    // reset state
    idle();
    rst_n = 1'b0;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    exp_cnt = 0;

    // directed table
    foreach (vecs[i]) begin
      apply(vecs[i]);
      if (vecs[i].valid) exp_cnt = exp_cnt + 1;
      step();
      chk_all(vecs[i].name, vecs[i].e_regwr, vecs[i].e_rw, vecs[i].e_busw, vecs[i].e_ovf, exp_cnt);
    end

    // overflow pulse lasts one cycle, then stalls must not repeat it
    v = vecs[1];
    v.alu = 32'h55;
    apply(v); exp_cnt = exp_cnt + 1;
    step();
    chk_all("ovf_cap", 0, 9, 32'h55, 1, exp_cnt);
    bus.stall = 1'b1;
    v = vecs[0]; v.rd = 5'd3; v.alu = 32'hAAAA;
    apply(v);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("ovf_stall", 0, 9, 32'h55, 0, exp_cnt);
    end
    bus.stall = 1'b0;

    // held write stays asserted while stalled
    v = vecs[0]; v.rd = 5'd12; v.alu = 32'h77;
    apply(v); exp_cnt = exp_cnt + 1;
    step();
    chk_all("wr_cap", 1, 12, 32'h77, 0, exp_cnt);
    bus.stall = 1'b1;
    apply(vecs[2]);
    for (int k = 0; k < 2; k++) begin
      step();
      chk_all("wr_stall", 1, 12, 32'h77, 0, exp_cnt);
    end

    // flush wins over stall
    bus.flush = 1'b1;
    apply(vecs[1]);
    step();
    chk_all("flush_stall", 0, 0, 0, 0, exp_cnt);
    bus.stall = 1'b0;
    apply(vecs[0]);
    step();
    chk_all("flush_only", 0, 0, 0, 0, exp_cnt);
    bus.flush = 1'b0;

    // reset while a valid write is presented
    apply(vecs[0]);
    step();
    rst_n = 1'b0;
    step();
    chk_all("rst_mid", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_all("rst_after", 1, 9, 32'h1234, 0, 1);

    // randomized traffic against the model
    rst_n = 1'b0;
    idle();
    model_edge();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rst_n          = ($urandom_range(0, 59) != 0);
      bus.stall      = ($urandom_range(0, 5) == 0);
      bus.flush      = ($urandom_range(0, 9) == 0);
      bus.m_valid    = ($urandom_range(0, 3) != 0);
      bus.m_RegWr    = 1'($urandom);
      bus.m_Overflow = ($urandom_range(0, 7) == 0);
      bus.m_RegDst   = 1'($urandom);
      bus.m_MemtoReg = 1'($urandom);
      bus.m_Link     = ($urandom_range(0, 7) == 0);
      bus.m_ldtype   = 3'($urandom_range(0, 7));
      bus.m_Rt       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      bus.m_Rd       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      bus.m_alu      = $urandom;
      bus.m_rdata    = $urandom;
      bus.m_pc       = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7))) : $urandom;
      model_edge();
      step();
      chk_all("rand", m_regwr, m_rw, m_busw, m_ovf, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
